// File: rtl/t_count_pkg.sv
// Shared state encoding and direction constants for the toggle-cell counter sequencer.
package t_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/t_cell.sv
// Single toggle flip-flop: q flips on the falling clock edge whenever t is high.
module t_cell (
    input  logic clock,
    input  logic reset_n,
    input  logic t,
    output logic q
);

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_count_sequencer.sv
// Up/down run sequencer driving a bank of toggle cells; the toggle network is the only count path.
module t_count_sequencer
    import t_count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             up_down,
    input  logic [WIDTH-1:0] limit,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_t;
    logic [WIDTH-1:0] tgl;
    logic             carry;

    assign end_val  = (dir_q == DIR_UP) ? limit_q : '0;
    assign load_val = (up_down == DIR_UP) ? '0 : limit;
    assign tc       = busy && (count == end_val);

    // Bit i toggles when all lower bits match the direction (all 1 up, all 0 down).
    always_comb begin
        step_t = '0;
        carry  = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            step_t[i] = carry;
            carry     = carry & (count[i] ~^ dir_q);
        end
    end

    // Loading is done through the cells too: toggling exactly the differing bits.
    always_comb begin
        tgl = '0;
        case (state)
            IDLE:    if (start) tgl = count ^ load_val;
            COUNT:   if (!tc && !hold) tgl = step_t;
            default: tgl = '0;
        endcase
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dir_q   <= DIR_UP;
            limit_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        limit_q <= limit;
                        dir_q   <= up_down;
                        state   <= COUNT;
                        busy    <= 1'b1;
                    end
                end
                COUNT: begin
                    if (count == end_val) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .t       (tgl[i]),
            .q       (count[i])
        );
    end

endmodule

// File: tb/tb_t_count_sequencer.sv
// Scoreboard bench: runs push expected per-cycle outputs, a monitor pops them while busy or done.
module tb_t_count_sequencer;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       up_down;
    logic [3:0] limit;
    logic       hold;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    typedef struct {
        logic [3:0] count;
        logic       busy;
        logic       tc;
        logic       done;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    t_count_sequencer #(.WIDTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .up_down (up_down),
        .limit   (limit),
        .hold    (hold),
        .count   (count),
        .busy    (busy),
        .tc      (tc),
        .done    (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: DUT state changes on negedge, so sampling on posedge is mid-cycle.
    always @(posedge clock) begin
        if (reset_n && (busy || done)) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got count=%0d busy=%0d done=%0d, required no output",
                         count, busy, done);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("mon_count", count, e.count);
                chk("mon_busy",  busy,  e.busy);
                chk("mon_tc",    tc,    e.tc);
                chk("mon_done",  done,  e.done);
            end
        end
    end

    task automatic push_exp(input logic [3:0] c, input logic b, input logic t, input logic d);
        exp_t e;
        e.count = c;
        e.busy  = b;
        e.tc    = t;
        e.done  = d;
        expq.push_back(e);
    endtask

    // One complete run; cycle c is the c-th posedge after the start edge.
    task automatic run(input logic up, input logic [3:0] lim, input int hold_at,
                       input int hold_len, input int restart_at, output logic [3:0] last);
        int         n;
        logic [3:0] v;
        logic [3:0] endv;
        v    = up ? 4'd0 : lim;
        endv = up ? lim : 4'd0;
        n    = 0;
        for (int c = 0; c < 40; c++) begin
            push_exp(v, 1'b1, v == endv, 1'b0);
            n++;
            if (v == endv) break;
            if (!(c >= hold_at && c < hold_at + hold_len))
                v = up ? v + 4'd1 : v - 4'd1;
        end
        push_exp(v, 1'b0, 1'b0, 1'b1);
        n++;
        last = v;

        @(posedge clock); #1;
        start   = 1'b1;
        up_down = up;
        limit   = lim;
        hold    = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clock); #1;
            start   = (c == restart_at);
            up_down = ~up;
            limit   = ~lim;
            hold    = (c >= hold_at && c < hold_at + hold_len);
        end
        start = 1'b0;
        hold  = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        logic [3:0] last;
        reset_n = 1'b0;
        start   = 1'b0;
        up_down = 1'b1;
        limit   = 4'd0;
        hold    = 1'b0;

        #2;
        chk("rst_count", count, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        chk("rst_tc",    tc,    0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Up run, limit 3: 0,1,2,3 then done, count holds at 3 in IDLE.
        run(1'b1, 4'd3, -1, 0, -1, last);
        chk("idle_after_up", count, 3);
        repeat (2) @(posedge clock);
        chk("idle_hold_up", count, 3);
        chk("idle_busy", busy, 0);
        chk("idle_tc", tc, 0);

        // Down run, limit 4, hold two cycles at count 2: 4,3,2,2,2,1,0.
        run(1'b0, 4'd4, 2, 2, -1, last);
        chk("idle_after_down", count, 0);

        // Full range up: all 16 values, no wrap.
        run(1'b1, 4'd15, -1, 0, -1, last);
        chk("idle_after_full", count, 15);

        // Full range down from 15 after a preceding run ended at 15.
        run(1'b0, 4'd15, -1, 0, -1, last);
        chk("idle_after_full_down", count, 0);

        // Limit zero: single COUNT cycle with tc.
        run(1'b1, 4'd0, -1, 0, -1, last);
        chk("idle_after_zero", count, 0);

        // Start pulse during COUNT of a limit-6 run is ignored.
        run(1'b1, 4'd6, -1, 0, 2, last);
        chk("idle_after_restart", count, 6);

        // Reset mid-run at count 5.
        for (int v = 0; v <= 5; v++) push_exp(4'(v), 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1;
        start   = 1'b1;
        up_down = 1'b1;
        limit   = 4'd10;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_busy",  busy,  0);
        chk("midrst_done",  done,  0);
        chk("midrst_tc",    tc,    0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        chk("midrst_queue_drained", expq.size(), 0);

        // Recovery run after reset.
        run(1'b1, 4'd2, -1, 0, -1, last);
        chk("idle_after_recover", count, 2);

        repeat (3) @(posedge clock);
        chk("final_queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_count_sequencer.md
Name: t_count_sequencer

Overview:
- Controller that sequences a bank of WIDTH toggle flip-flop cells as a synchronous programmable up/down counter.
- Accepts a start request with a limit value and counts between 0 and the limit.
- Reports busy, terminal count and a one-cycle done pulse.
- Used as the step/timing sequencer for the lab datapaths built from toggle cells.

Parameters:
- WIDTH, 4, bit width of the counter, the limit and the toggle-cell bank.

Ports:
- clock  input  1  system clock; all state updates on the falling edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a count run; sampled only in IDLE.
- up_down  input  1  direction, sampled with start: 1 = up (0 to limit), 0 = down (limit to 0).
- limit  input  WIDTH  run bound, sampled with start.
- hold  input  1  freezes counting while high (COUNT state only).
- count  output  WIDTH  current value of the toggle-cell bank.
- busy  output  1  high while in COUNT.
- tc  output  1  combinational; high in COUNT when count equals the end value.
- done  output  1  high for exactly one cycle (DONE state).

Behaviour:
- Reset (reset_n=0, asynchronous, dominates everything): state=IDLE, count=0, dir_q=1, limit_q=0, busy=0, done=0, tc=0. Release takes effect at the next falling edge.
- Clocking: one clock domain. Every register, including the toggle cells, updates on the negedge of clock.
- FSM states: IDLE, COUNT, DONE. Encoding is held in the shared package.
- IDLE:
  - start=1 at an edge: limit_q<=limit, dir_q<=up_down, count<=0 if up or limit if down, state<=COUNT.
  - start=0: count holds its last value.
- COUNT:
  - End value is limit_q if up, 0 if down.
  - If count==end at an edge: state<=DONE, no toggle.
  - Else if hold=1: no toggle, state stays COUNT.
  - Else count steps by ±1 through toggle enables.
- Toggle enables:
  - up: T[0]=1, T[i]=&count[i-1:0].
  - down: T[0]=1, T[i]=&(~count[i-1:0]).
  - Each cell computes q<=q^T.
  - No adder; the toggle network is the only count path.
- DONE: done=1 for one cycle, count holds, next edge state<=IDLE. hold and start are ignored here.
- start while in COUNT or DONE: ignored. A new run needs start high in IDLE, so back-to-back runs have a minimum of one IDLE cycle.
- Latency for an up run with limit L and no hold:
  - start edge loads 0.
  - L edges bring count to L.
  - next edge enters DONE.
  - next edge returns to IDLE.
  - busy is high for L+1 cycles; done is high 1 cycle.
- limit=0: one COUNT cycle with tc=1, then DONE. count stays 0.
- Wrap-around: cannot occur, because the end value is always reached before overflow. Toggle cells therefore never wrap past 2^WIDTH-1 or below 0.
- Changing limit or up_down mid-run: no effect, only the latched copies are used.
- reset_n low mid-run: immediate return to the reset values, no done pulse.

Decomposition:
- Package t_count_pkg: state enum (IDLE=2'b00, COUNT=2'b01, DONE=2'b10), direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
- Sub-module t_cell: a single toggle flip-flop with async active-low reset, toggle-enable input T, negedge clock and output q. It is instantiated WIDTH times by a generate loop.
- The FSM and the toggle-enable network live in the top module.

Test Plan:
- Reset mid-run: assert reset_n=0 during COUNT at count=5 (WIDTH=4) -> count=0, busy=0, done=0, state IDLE immediately, without waiting for a clock edge.
- Up run: start=1, up_down=1, limit=3 -> count 0,1,2,3 on successive falling edges. tc=1 when count=3. done high for one cycle on the next edge, then IDLE with count=3. busy is high for 4 cycles.
- Down run with hold: start, up_down=0, limit=4, hold=1 for 2 cycles at count=2 -> count sequence 4,3,2,2,2,1,0, then done.
- Full range: WIDTH=4, limit=15, up -> all 16 values are visited. Bits 0-3 toggle only when the lower bits are all 1, and there is no wrap to 0.
- Limit zero and ignored start: limit=0 gives a single COUNT cycle with tc=1, then done, with count staying 0. A second start pulse raised during COUNT of a limit=6 run is ignored, with no reload and the run finishing at 6.
